// File: rtl/cpu_seq.sv
// cpu_seq: variable-length fetch/decode/execute control sequencer with a RAM-ready
// handshake, halt/resume, wait timeout and end-of-instruction pulse. Optional: CPU_SEQ_ILLEGAL_TRAP_EN.
module cpu_seq #(
  parameter int MAX_CYCLES   = 12,
  parameter int CYCLE_W      = 4,
  parameter int WAIT_TIMEOUT = 15,
  parameter int STATE_W      = 8
) (
  input  logic               clk,
  input  logic               reset_cycle_n,
  input  logic [7:0]         instruction,
  input  logic               mem_ready,
  input  logic               resume,
  output logic [STATE_W-1:0] state,
  output logic [CYCLE_W-1:0] cycle,
  output logic [7:0]         opcode,
  output logic               instr_done,
  output logic               halted,
  output logic               fault
);

  typedef enum logic [4:0] {
    ST_NEXT       = 5'h00, ST_FETCH_PC   = 5'h01, ST_FETCH_INST = 5'h02,
    ST_HALT       = 5'h03, ST_JUMP       = 5'h04, ST_OUT        = 5'h05,
    ST_ALU_OUT    = 5'h06, ST_ALU_EXEC   = 5'h07, ST_MOV_STORE  = 5'h08,
    ST_MOV_FETCH  = 5'h09, ST_MOV_LOAD   = 5'h0A, ST_FETCH_SP   = 5'h0C,
    ST_PC_STORE   = 5'h0D, ST_TMP_JUMP   = 5'h0E, ST_RET        = 5'h0F,
    ST_INC_SP     = 5'h10, ST_SET_ADDR   = 5'h11, ST_IN         = 5'h12,
    ST_REG_STORE  = 5'h13, ST_SET_REG    = 5'h14, ST_LOAD_IMM   = 5'h15,
    ST_WAIT_RAM   = 5'h16, ST_FAULT      = 5'h17
  } state_e;

  typedef enum logic [7:0] {
    OP_NOP = 8'h00, OP_CALL = 8'h01, OP_RET = 8'h02, OP_OUT = 8'h03,
    OP_IN  = 8'h04, OP_HLT  = 8'h05, OP_CMP = 8'h06, OP_LDI = 8'h10,
    OP_JMP = 8'h18, OP_PUSH = 8'h20, OP_POP = 8'h28, OP_ALU = 8'h40,
    OP_MOV = 8'h80
  } op_e;

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
  localparam bit ILLEGAL_TRAP = 1'b1;
`else
  localparam bit ILLEGAL_TRAP = 1'b0;
`endif

  localparam int STALL_W = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);

  if (MAX_CYCLES < 10) begin : g_bad_max_cycles
    $error("cpu_seq: MAX_CYCLES must be at least 10");
  end
  if ((2 ** CYCLE_W) < MAX_CYCLES) begin : g_bad_cycle_w
    $error("cpu_seq: CYCLE_W too narrow for MAX_CYCLES");
  end
  if (STATE_W < 8) begin : g_bad_state_w
    $error("cpu_seq: STATE_W must be at least 8");
  end

  function automatic op_e decode(input logic [7:0] b);
    casez (b)
      8'b0000_0000: return OP_NOP;
      8'b0000_0001: return OP_CALL;
      8'b0000_0010: return OP_RET;
      8'b0000_0011: return OP_OUT;
      8'b0000_0100: return OP_IN;
      8'b0000_0101: return OP_HLT;
      8'b0000_0110: return OP_CMP;
      8'b0001_0???: return OP_LDI;
      8'b0001_1???: return OP_JMP;
      8'b0010_0???: return OP_PUSH;
      8'b0010_1???: return OP_POP;
      8'b01??_?000: return OP_ALU;
      8'b10??_????: return OP_MOV;
      default:      return OP_NOP;
    endcase
  endfunction

  function automatic logic is_legal(input logic [7:0] b);
    casez (b)
      8'b0000_0000, 8'b0000_0001, 8'b0000_0010, 8'b0000_0011,
      8'b0000_0100, 8'b0000_0101, 8'b0000_0110,
      8'b0001_????, 8'b0010_????, 8'b01??_?000, 8'b10??_????: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Number of execute steps after c4; zero means c4 is already the last step.
  function automatic logic [2:0] seq_len(input op_e op);
    case (op)
      OP_CMP, OP_HLT:                         return 3'd1;
      OP_ALU, OP_JMP, OP_LDI, OP_PUSH:        return 3'd2;
      OP_MOV, OP_POP, OP_RET, OP_OUT, OP_IN:  return 3'd3;
      OP_CALL:                                return 3'd5;
      default:                                return 3'd0;
    endcase
  endfunction

  function automatic state_e seq_state(input op_e op, input logic [2:0] k);
    case (op)
      OP_CMP:  return ST_ALU_EXEC;
      OP_HLT:  return ST_HALT;
      OP_ALU:  return (k == 3'd0) ? ST_ALU_EXEC : ST_ALU_OUT;
      OP_JMP:  return (k == 3'd0) ? ST_FETCH_PC : ST_JUMP;
      OP_LDI:  return (k == 3'd0) ? ST_FETCH_PC : ST_LOAD_IMM;
      OP_PUSH: return (k == 3'd0) ? ST_FETCH_SP : ST_REG_STORE;
      OP_MOV:  return (k == 3'd0) ? ST_MOV_FETCH : (k == 3'd1) ? ST_MOV_LOAD : ST_MOV_STORE;
      OP_POP:  return (k == 3'd0) ? ST_INC_SP : (k == 3'd1) ? ST_FETCH_SP : ST_SET_REG;
      OP_RET:  return (k == 3'd0) ? ST_INC_SP : (k == 3'd1) ? ST_FETCH_SP : ST_RET;
      OP_OUT:  return (k == 3'd0) ? ST_FETCH_PC : (k == 3'd1) ? ST_SET_ADDR : ST_OUT;
      OP_IN:   return (k == 3'd0) ? ST_FETCH_PC : (k == 3'd1) ? ST_SET_ADDR : ST_IN;
      OP_CALL: begin
        case (k)
          3'd0:    return ST_FETCH_PC;
          3'd1:    return ST_SET_REG;
          3'd2:    return ST_FETCH_SP;
          3'd3:    return ST_PC_STORE;
          default: return ST_TMP_JUMP;
        endcase
      end
      default: return ST_FETCH_PC;
    endcase
  endfunction

  state_e             st;
  op_e                op_q;
  logic [7:0]         ir_q;
  logic [STALL_W-1:0] stall_q;
  logic [CYCLE_W-1:0] cycle_inc;
  logic [2:0]         exec_idx;
  state_e             exec_state;
  logic               exec_last;

  // Execute index of the step being entered on the next edge (meaningful from c4 on).
  assign cycle_inc  = cycle + CYCLE_W'(1);
  assign exec_idx   = 3'(cycle_inc - CYCLE_W'(5));
  assign exec_state = seq_state(op_q, exec_idx);
  assign exec_last  = ((exec_idx + 3'd1) == seq_len(op_q));

  assign state  = STATE_W'(st);
  assign opcode = op_q;

  // NOTE: all sequencer state uses non-blocking assignments so every register
  // updates from the values present before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge reset_cycle_n) begin
    if (!reset_cycle_n) begin
      st         <= ST_FETCH_PC;
      cycle      <= '0;
      op_q       <= OP_NOP;
      ir_q       <= '0;
      stall_q    <= '0;
      instr_done <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else if (st == ST_FAULT) begin
      instr_done <= 1'b0;
    end else if (st == ST_HALT) begin
      instr_done <= 1'b0;
      if (resume) begin
        st     <= ST_FETCH_PC;
        cycle  <= '0;
        halted <= 1'b0;
      end
    end else if (instr_done || (cycle >= CYCLE_W'(MAX_CYCLES - 1))) begin
      st         <= ST_FETCH_PC;
      cycle      <= '0;
      instr_done <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      cycle      <= cycle_inc;
      case (cycle)
        CYCLE_W'(0): st <= ST_WAIT_RAM;
        CYCLE_W'(1): begin
          if (mem_ready) begin
            st      <= ST_FETCH_INST;
            stall_q <= '0;
          end else begin
            cycle <= cycle;
            if (WAIT_TIMEOUT != 0) begin
              stall_q <= stall_q + STALL_W'(1);
              if (stall_q == STALL_W'(WAIT_TIMEOUT - 1)) begin
                st    <= ST_FAULT;
                fault <= 1'b1;
              end
            end
          end
        end
        CYCLE_W'(2): begin
          st   <= ST_NEXT;
          ir_q <= instruction;
        end
        CYCLE_W'(3): begin
          st         <= ST_NEXT;
          op_q       <= decode(ir_q);
          instr_done <= (decode(ir_q) == OP_NOP) && (!ILLEGAL_TRAP || is_legal(ir_q));
        end
        default: begin
          if (ILLEGAL_TRAP && (cycle == CYCLE_W'(4)) && !is_legal(ir_q)) begin
            st    <= ST_FAULT;
            fault <= 1'b1;
          end else begin
            st         <= exec_state;
            instr_done <= exec_last;
            halted     <= (exec_state == ST_HALT);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: directed scoreboard bench for cpu_seq (default build, trap feature off).
module tb_cpu_seq;

  logic       clk;
  logic       reset_cycle_n;
  logic [7:0] instruction;
  logic       mem_ready;
  logic       resume;
  logic [7:0] state;
  logic [3:0] cycle;
  logic [7:0] opcode;
  logic       instr_done;
  logic       halted;
  logic       fault;

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_op;

  typedef struct packed {
    logic [7:0] st;
    logic [3:0] cyc;
    logic [7:0] op;
    logic       done;
    logic       halt;
    logic       flt;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  e;
  } sb_t;

  sb_t sb[$];

  cpu_seq dut (
    .clk          (clk),
    .reset_cycle_n(reset_cycle_n),
    .instruction  (instruction),
    .mem_ready    (mem_ready),
    .resume       (resume),
    .state        (state),
    .cycle        (cycle),
    .opcode       (opcode),
    .instr_done   (instr_done),
    .halted       (halted),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input obs_t exp);
    obs_t obs;
    obs = {state, cycle, opcode, instr_done, halted, fault};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed st=%h cyc=%0d op=%h done=%b halted=%b fault=%b, expected st=%h cyc=%0d op=%h done=%b halted=%b fault=%b",
             tag, obs.st, obs.cyc, obs.op, obs.done, obs.halt, obs.flt,
             exp.st, exp.cyc, exp.op, exp.done, exp.halt, exp.flt);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] st, input logic [3:0] cyc,
                      input logic [7:0] op, input logic done, input logic halt, input logic flt);
    sb_t item;
    item.tag = $sformatf("%s c%0d", tag, cyc);
    item.e   = '{st, cyc, op, done, halt, flt};
    sb.push_back(item);
  endtask

  // One queued expectation per clock edge, sampled 1 time unit after the edge.
  task automatic run_sb();
    sb_t item;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      item = sb.pop_front();
      check(item.tag, item.e);
    end
  endtask

  // Runs one instruction from c0; ex packs up to five execute states, first in the top byte.
  task automatic do_instr(input string tag, input logic [7:0] ins, input logic [7:0] op,
                          input int n_stall, input logic [39:0] ex, input int n, input int n_show);
    logic [7:0] s;
    instruction = ins;
    mem_ready   = (n_stall == 0);
    push(tag, 8'h16, 4'd1, prev_op, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n_stall; i++) push(tag, 8'h16, 4'd1, prev_op, 1'b0, 1'b0, 1'b0);
    run_sb();
    mem_ready = 1'b1;
    push(tag, 8'h02, 4'd2, prev_op, 1'b0, 1'b0, 1'b0);
    push(tag, 8'h00, 4'd3, prev_op, 1'b0, 1'b0, 1'b0);
    push(tag, 8'h00, 4'd4, op, (n == 0), 1'b0, 1'b0);
    for (int k = 0; k < n_show; k++) begin
      s = ex[39 - 8*k -: 8];
      push(tag, s, 4'(5 + k), op, (k == n - 1), (s == 8'h03), 1'b0);
    end
    if (n_show == n && op != 8'h05) push(tag, 8'h01, 4'd0, op, 1'b0, 1'b0, 1'b0);
    run_sb();
    prev_op = op;
  endtask

  initial begin
    reset_cycle_n = 1'b1;
    instruction   = 8'h00;
    mem_ready     = 1'b1;
    resume        = 1'b0;
    prev_op       = 8'h00;
    #1 reset_cycle_n = 1'b0;
    #2 check("reset", {8'h01, 4'd0, 8'h00, 3'b000});
    #4 reset_cycle_n = 1'b1;

    do_instr("nop",         8'h00, 8'h00, 0,  40'h0, 0, 0);
    do_instr("alu",         8'h48, 8'h40, 0,  {8'h07, 8'h06, 24'h0}, 2, 2);
    do_instr("call",        8'h01, 8'h01, 0,  {8'h01, 8'h14, 8'h0C, 8'h0D, 8'h0E}, 5, 5);
    do_instr("cmp_stall3",  8'h06, 8'h06, 3,  {8'h07, 32'h0}, 1, 1);
    do_instr("ldi_stall14", 8'h13, 8'h10, 14, {8'h01, 8'h15, 24'h0}, 2, 2);

    do_instr("hlt", 8'h05, 8'h05, 0, {8'h03, 32'h0}, 1, 1);
    push("halt_hold", 8'h03, 4'd5, 8'h05, 1'b0, 1'b1, 1'b0);
    push("halt_hold", 8'h03, 4'd5, 8'h05, 1'b0, 1'b1, 1'b0);
    run_sb();
    resume = 1'b1;
    push("resume", 8'h01, 4'd0, 8'h05, 1'b0, 1'b0, 1'b0);
    run_sb();

    // Undecodable byte runs as NOP; resume stays high here and must be ignored.
    do_instr("illegal_ff", 8'hFF, 8'h00, 0, 40'h0, 0, 0);
    resume = 1'b0;

    instruction = 8'h00;
    mem_ready   = 1'b0;
    push("timeout", 8'h16, 4'd1, prev_op, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) push("timeout", 8'h16, 4'd1, prev_op, 1'b0, 1'b0, 1'b0);
    push("timeout", 8'h17, 4'd1, prev_op, 1'b0, 1'b0, 1'b1);
    run_sb();
    mem_ready = 1'b1;
    resume    = 1'b1;
    push("fault_hold", 8'h17, 4'd1, prev_op, 1'b0, 1'b0, 1'b1);
    push("fault_hold", 8'h17, 4'd1, prev_op, 1'b0, 1'b0, 1'b1);
    run_sb();
    resume = 1'b0;
    reset_cycle_n = 1'b0;
    #1 check("fault_reset", {8'h01, 4'd0, 8'h00, 3'b000});
    #2 reset_cycle_n = 1'b1;
    prev_op = 8'h00;

    // Abort MOV during c6 with an asynchronous reset.
    do_instr("mov_abort", 8'h85, 8'h80, 0, {8'h09, 8'h0A, 8'h08, 16'h0}, 3, 2);
    reset_cycle_n = 1'b0;
    #1 check("mov_reset", {8'h01, 4'd0, 8'h00, 3'b000});
    #2 reset_cycle_n = 1'b1;
    prev_op = 8'h00;

    do_instr("jmp", 8'h1F, 8'h18, 0, {8'h01, 8'h04, 24'h0}, 2, 2);
    do_instr("ret", 8'h02, 8'h02, 0, {8'h10, 8'h0C, 8'h0F, 16'h0}, 3, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
